// File: rtl/lcd_rd.sv
// lcd_rd: reads the four counter digits back from HD44780 DDRAM and decodes them
module lcd_rd #(
  parameter int         CLK_DIV   = 50,
  parameter logic [6:0] BASE_ADDR = 7'h4C,
  parameter int         BF_LIMIT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] DB_in,
  output logic [7:0] DB_out,
  output logic       DB_oe,
  output logic       E,
  output logic       RS,
  output logic       RW,
  output logic       busy,
  output logic       done,
  output logic [3:0] count0,
  output logic [3:0] count1,
  output logic [3:0] count2,
  output logic [3:0] count3,
  output logic       valid,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, BF_POLL, SET_ADDR, BF_POLL2, RD_CHAR, FINISH} state_t;
  typedef enum logic [1:0] {SETUP, HIGH, LOW} phase_t;
  state_t state;
  phase_t phase;
  logic [7:0] div, polls, rd_q;
  logic [1:0] idx;
  logic [3:0][3:0] sh;
  logic err_s;
  logic last, acc_end, poll_to, ch_bad;
  assign last    = div == 8'(CLK_DIV - 1);
  assign acc_end = last && phase == LOW;
  assign poll_to = polls == 8'(BF_LIMIT - 1);
  assign ch_bad  = rd_q[7:4] != 4'h3 || rd_q[3:0] > 4'd9;
  // Bus phase sequencing plus transaction FSM; decisions are taken at the end of each access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      phase <= SETUP;
      div <= '0;
      polls <= '0;
      rd_q <= '0;
      idx <= '0;
      sh <= '0;
      err_s <= 1'b0;
      DB_out <= 8'h00;
      DB_oe <= 1'b0;
      E <= 1'b0;
      RS <= 1'b0;
      RW <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      count0 <= '0;
      count1 <= '0;
      count2 <= '0;
      count3 <= '0;
      valid <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && state != FINISH) begin
        div <= last ? 8'd0 : div + 8'd1;
        if (last) begin
          phase <= phase == SETUP ? HIGH : phase == HIGH ? LOW : SETUP;
          E <= phase == SETUP;
        end
        if (last && phase == HIGH) rd_q <= DB_in;
      end
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          state <= BF_POLL;
          phase <= SETUP;
          div <= '0;
          polls <= '0;
          sh <= '0;
          err_s <= 1'b0;
          valid <= 1'b0;
          err <= 1'b0;
          RS <= 1'b0;
          RW <= 1'b1;
          DB_oe <= 1'b0;
        end
        BF_POLL, BF_POLL2: if (acc_end) begin
          if (!rd_q[7]) begin
            polls <= '0;
            if (state == BF_POLL) begin
              state <= SET_ADDR;
              RW <= 1'b0;
              DB_oe <= 1'b1;
              DB_out <= {1'b1, BASE_ADDR};
            end else begin
              state <= RD_CHAR;
              RS <= 1'b1;
            end
          end else if (poll_to) begin
            err_s <= 1'b1;
            err <= 1'b1;
            valid <= 1'b0;
            state <= FINISH;
          end else polls <= polls + 8'd1;
        end
        SET_ADDR: if (acc_end) begin
          state <= BF_POLL2;
          idx <= '0;
          RW <= 1'b1;
          DB_oe <= 1'b0;
          DB_out <= 8'h00;
        end
        RD_CHAR: if (acc_end) begin
          sh[~idx] <= rd_q[3:0];
          if (ch_bad) err_s <= 1'b1;
          RS <= 1'b0;
          idx <= idx + 2'd1;
          state <= idx == 2'd3 ? FINISH : BF_POLL2;
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
          valid <= !err_s;
          err <= err_s;
          if (!err_s) begin
            count3 <= sh[3];
            count2 <= sh[2];
            count1 <= sh[1];
            count0 <= sh[0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_rd.sv
// tb_lcd_rd: directed checks of lcd_rd against a behavioural HD44780 bus model
module tb_lcd_rd;
  logic clk = 0, rst = 1, start = 0;
  logic [7:0] db_in, db_out;
  logic db_oe, e, rs, rw, busy, done, valid, err;
  logic [3:0] c0, c1, c2, c3;
  int checks = 0, errors = 0;
  int poll_total = 0, rs_total = 0, wr_total = 0, oe_viol = 0;
  logic [7:0] wr_val = 0;
  logic [1:0] wr_ctl = 0;
  logic [1:0] ptr = 0;
  int bf_until = 0;
  logic [7:0] chars [4];
  int lat, p0, r0, w0, n, d;

  always #5 clk = ~clk;

  lcd_rd #(.CLK_DIV(2), .BF_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .DB_in(db_in), .DB_out(db_out), .DB_oe(db_oe),
    .E(e), .RS(rs), .RW(rw), .busy(busy), .done(done),
    .count0(c0), .count1(c1), .count2(c2), .count3(c3), .valid(valid), .err(err));

  assign db_in = rs ? chars[ptr] : {poll_total < bf_until, 7'b0};

  // LCD model: access bookkeeping at E rise, address/poll advance at E fall
  always @(posedge e) begin
    if (rw && db_oe) oe_viol <= oe_viol + 1;
    if (rs) rs_total <= rs_total + 1;
    if (!rw) begin
      wr_total <= wr_total + 1;
      wr_val <= db_out;
      wr_ctl <= {rs, rw};
      if (db_out == 8'hCC) ptr <= 0;
    end
  end
  always @(negedge e) begin
    if (rs && rw) ptr <= ptr + 2'd1;
    if (!rs && rw) poll_total <= poll_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [31:0] s, input int stall, input bit poke);
    chars[0] = s[31:24]; chars[1] = s[23:16]; chars[2] = s[15:8]; chars[3] = s[7:0];
    bf_until = poll_total + stall;
    p0 = poll_total; r0 = rs_total; w0 = wr_total;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("busy_rise", busy, 1);
    chk("flags_clr", {valid, err}, 0);
    lat = 0;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
      start = poke && lat == 20;
    end
    start = 0;
    chk("busy_end", busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl", {e, rs, rw, db_oe, busy, done, valid, err}, 8'b0010_0000);
    chk("rst_db", db_out, 8'h00);
    chk("rst_cnt", {c3, c2, c1, c0}, 0);
    rst = 0;
    // clean read of "1907"
    run("1907", 0, 0);
    chk("t1_lat", lat, 61);
    chk("t1_cnt", {c3, c2, c1, c0}, 16'h1907);
    chk("t1_flags", {valid, err}, 2'b10);
    chk("t1_writes", wr_total - w0, 1);
    chk("t1_wr_val", wr_val, 8'hCC);
    chk("t1_wr_ctl", wr_ctl, 2'b00);
    chk("t1_reads", rs_total - r0, 4);
    chk("t1_polls", poll_total - p0, 5);
    // three busy polls on the first access
    run("2468", 3, 0);
    chk("t2_lat", lat, 79);
    chk("t2_cnt", {c3, c2, c1, c0}, 16'h2468);
    chk("t2_flags", {valid, err}, 2'b10);
    chk("t2_polls", poll_total - p0, 8);
    // third character 'A' is not a digit
    run({"5", "3", 8'h41, "8"}, 0, 0);
    chk("t3_lat", lat, 61);
    chk("t3_flags", {valid, err}, 2'b01);
    chk("t3_cnt", {c3, c2, c1, c0}, 16'h2468);
    chk("t3_reads", rs_total - r0, 4);
    chk("t3_writes", wr_total - w0, 1);
    // busy flag stuck: abort after four polls
    run("9999", 1000, 0);
    chk("t4_lat", lat, 25);
    chk("t4_flags", {valid, err}, 2'b01);
    chk("t4_cnt", {c3, c2, c1, c0}, 16'h2468);
    chk("t4_polls", poll_total - p0, 4);
    chk("t4_no_rs", rs_total - r0, 0);
    chk("t4_no_wr", wr_total - w0, 0);
    // reset while a character read has E high
    chars[0] = "1"; chars[1] = "1"; chars[2] = "1"; chars[3] = "1";
    bf_until = poll_total;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    n = 0;
    while (!(e && rs) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_rd", n < 500, 1);
    #1 rst = 1;
    #1 chk("t5_async", {e, busy, rw, db_oe, done}, 5'b00100);
    @(negedge clk) rst = 0;
    d = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) d++;
    end
    chk("t5_no_done", d, 0);
    chk("t5_cnt", {c3, c2, c1, c0}, 0);
    run("4209", 0, 0);
    chk("t5_lat", lat, 61);
    chk("t5_cnt2", {c3, c2, c1, c0}, 16'h4209);
    // start pulsed while busy is ignored
    run("7731", 0, 1);
    chk("t6_lat", lat, 61);
    chk("t6_cnt", {c3, c2, c1, c0}, 16'h7731);
    chk("t6_writes", wr_total - w0, 1);
    chk("t6_reads", rs_total - r0, 4);
    chk("t6_polls", poll_total - p0, 5);
    repeat (10) @(negedge clk);
    chk("t6_idle", busy, 0);
    chk("oe_during_read", oe_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_rd.md
# lcd_rd

Read-back engine for the character LCD (HD44780-style 8-bit bus). It repositions the DDRAM address to the counter display field (command 0xCC, line 2 column 12) and reads the four ASCII digits back. It decodes them into the same four 4-bit digit values that the display datapath writes. It sits beside the LCD write path and owns the bus only while `busy` is high; it is used for display self-check and for the safe-code readback.

## Interface
Parameters:
- `CLK_DIV`, default 50: clocks per bus phase (setup, E-high, E-low); legal range is 1–255.
- `BASE_ADDR`, default 7'h4C: DDRAM address of the leftmost digit. The set-address command is {1'b1, BASE_ADDR}, which is 0xCC.
- `BF_LIMIT`, default 255: maximum busy-flag polls per access before abort.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: single-cycle request; ignored while `busy`.
- `DB_in`, in, 8: LCD data bus as read from the pad.
- `DB_out`, out, 8: value driven onto the bus when `DB_oe` = 1.
- `DB_oe`, out, 1: bus output enable; high only during the set-address write access.
- `E`, out, 1: LCD enable strobe.
- `RS`, out, 1: register select (0 = instruction/busy flag, 1 = data).
- `RW`, out, 1: 1 = read, 0 = write.
- `busy`, out, 1: high from the cycle after accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse when a transaction ends, whether it succeeds or aborts.
- `count0`, `count1`, `count2`, `count3`, out, 4 each: decoded digits. `count3` is the leftmost character (first read) and `count0` is the rightmost.
- `valid`, out, 1: last transaction read four characters in range 0x30–0x39.
- `err`, out, 1: last transaction saw a non-digit character or a busy-flag timeout.

## Operation
- Reset values: `E`=0, `RS`=0, `RW`=1, `DB_oe`=0, `DB_out`=8'h00, `busy`=0, `done`=0, `count0`–`count3`=4'h0, `valid`=0, `err`=0. The FSM is in IDLE.
- Access primitive: each access has three phases of `CLK_DIV` clocks each.
  - SETUP: `RS`/`RW` (and `DB_out`/`DB_oe` for a write) are set, `E`=0.
  - HIGH: `E`=1.
  - LOW: `E`=0.
  - `RS`, `RW`, `DB_oe` and `DB_out` are constant across all three phases.
  - For reads, `DB_in` is registered on the last clock of HIGH.
- FSM states: IDLE, BF_POLL, SET_ADDR, BF_POLL2, RD_CHAR, FINISH.
  - IDLE: on `start`, clear the shadow registers and the error flag, set `busy`, and go to BF_POLL.
  - BF_POLL: read access with `RS`=0, `RW`=1.
    - If sampled bit 7 = 1, repeat the poll. The poll counter increments on each repeat.
    - If bit 7 = 0, go to SET_ADDR.
    - If the counter reaches `BF_LIMIT` with bit 7 still 1, set `err`, clear `valid`, and go to FINISH. The count registers are not updated.
  - SET_ADDR: write access with `RS`=0, `RW`=0, `DB_oe`=1, `DB_out`={1'b1, BASE_ADDR}. Then go to BF_POLL2 with char index 0.
  - BF_POLL2: same as BF_POLL (same timeout rule). On bit 7 = 0, go to RD_CHAR.
  - RD_CHAR: read access with `RS`=1, `RW`=1. The LCD auto-increments its address.
    - Store the low nibble of the sampled byte into shadow slot (3 − index).
    - If the high nibble ≠ 4'h3 or the low nibble > 9, set the shadow error flag.
    - If index < 3, increment index and return to BF_POLL2. Otherwise go to FINISH.
  - FINISH (one clock): pulse `done`, clear `busy`, return to IDLE.
    - On success, commit the shadow digits to `count0`–`count3` in the same clock.
    - Set `valid` = !error and `err` = error.
- Visibility rules:
  - `count*` change only at FINISH; they never show a partial update.
  - `valid` and `err` hold their values until the next accepted `start`, which clears both.
- Reset mid-transaction: all outputs return to their reset values immediately and asynchronously. `E` drops without completing the phase, and no `done` is issued.

## Timing
- `start` is sampled on a rising edge. `busy` rises on the next edge, and the first SETUP phase begins on that same edge.
- One access = 3·`CLK_DIV` clocks.
- A transaction with no busy stalls is 10 accesses (BF, SET, then BF+RD ×4) plus FINISH: 30·`CLK_DIV` + 1 clocks from the `busy` rise to the `done` pulse.
- Each extra busy poll adds 3·`CLK_DIV` clocks.
- `E` high width is exactly `CLK_DIV` clocks. Address/control setup before `E` rises is exactly `CLK_DIV` clocks.
- `DB_oe` is never high during an `E`-high phase of a read access.

## Test plan
- `CLK_DIV`=2; model returns BF=0 and the characters "1","9","0","7" → `done` 61 clocks after `busy` rises; `count3..0`=1,9,0,7; `valid`=1; `err`=0; exactly one write observed, with `DB_out`=0xCC, `RS`=0, `RW`=0.
- Model holds BF=1 for 3 polls on the first access only → `done` latency grows by 18 clocks; digits correct.
- Third character is 0x41 ('A') → `err`=1, `valid`=0; `count*` hold their previous values; all 10 accesses are still performed.
- BF stuck at 1 with `BF_LIMIT`=4 → abort after 4 polls; `done` pulses; `err`=1; no RS=1 access ever issued.
- Assert `rst` during RD_CHAR with `E` high → `E`=0, `busy`=0, `RW`=1, `DB_oe`=0 within the same cycle; no `done`. A new `start` then completes normally.
- Pulse `start` while `busy` → ignored; transaction count and timing are unchanged.
